// File: rtl/zports_if.sv
// ZX-bus port write strobe bundle between the port decoder and the zports register bank.
// Write handshake: the decoder drives ports_addr, ports_wrdata and ports_wrena stable
// for the whole interval ports_wrstb_n is low. That low interval lasts at least three fclk
// cycles and carries exactly one write. ports_rddata is a combinational readback of the
// register selected by ports_addr.
interface zports_if;
    logic       ports_wrena;
    logic       ports_wrstb_n;
    logic [1:0] ports_addr;
    logic [7:0] ports_wrdata;
    logic [7:0] ports_rddata;

    modport master (
        output ports_wrena,
        output ports_wrstb_n,
        output ports_addr,
        output ports_wrdata,
        input  ports_rddata
    );

    modport slave (
        input  ports_wrena,
        input  ports_wrstb_n,
        input  ports_addr,
        input  ports_wrdata,
        output ports_rddata
    );
endinterface

// File: rtl/zports.sv
// Register bank, W5300/SL811 reset sequencer and interrupt latch behind the ZX port decoder.
// Optional interrupt block (INT register, source syncs, int_req) enabled by `define ZPORTS_INT_EN.
module zports #(
    parameter int RST_LEN = 200,
    parameter int RCV_LEN = 2000
) (
    input  logic       fclk,
    input  logic       rst_n,
    input  logic       zrst_n,
    zports_if.slave    bus,
    output logic [1:0] rommap_win,
    output logic       rommap_ena,
    output logic       w5300_ports,
    output logic       w5300_rst_n,
    output logic       sl811_rst_n,
    input  logic       w5300_int_n,
    input  logic       sl811_intrq,
    output logic       int_req,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RECOVER = 2'd2
    } state_e;

    localparam logic [15:0] RST_RELOAD = 16'(RST_LEN - 1);
    localparam logic [15:0] RCV_RELOAD = 16'(RCV_LEN - 1);

    // Strobe synchronizer: [0],[1] are the 2-FF sync, [2] is the delayed copy for edge detect.
    logic [2:0] stb_q;
    logic [1:0] zrst_q;
    logic       wr_pulse;
    logic       soft_rst;
    logic       wr_cfg;
    logic       wr_rst;
    logic       wr_int;

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            stb_q  <= 3'b111;
            zrst_q <= 2'b11;
        end else begin
            stb_q  <= {stb_q[1:0], bus.ports_wrstb_n};
            zrst_q <= {zrst_q[0], zrst_n};
        end
    end

    assign wr_pulse = stb_q[2] & ~stb_q[1];
    assign soft_rst = ~zrst_q[1];
    assign wr_cfg   = wr_pulse & bus.ports_wrena & (bus.ports_addr == 2'b01);
    assign wr_rst   = wr_pulse & bus.ports_wrena & (bus.ports_addr == 2'b10);
    assign wr_int   = wr_pulse & bus.ports_wrena & (bus.ports_addr == 2'b11);

    logic [3:0] cfg_q;
    logic [3:0] cfg_d;

    always_comb begin
        cfg_d = cfg_q;
        if (soft_rst) begin
            cfg_d = 4'h0;
        end else if (wr_cfg) begin
            cfg_d = bus.ports_wrdata[3:0];
        end
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= 4'h0;
        end else begin
            cfg_q <= cfg_d;
        end
    end

    state_e      state_q;
    logic [15:0] cnt_q;
    logic        w5300_rst_q;
    logic        sl811_rst_q;
    logic        busy;

    // Reset sequencer: power-on and soft reset both land in ASSERT with both chips held.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ASSERT;
            cnt_q       <= RST_RELOAD;
            w5300_rst_q <= 1'b0;
            sl811_rst_q <= 1'b0;
        end else if (soft_rst) begin
            state_q     <= ST_ASSERT;
            cnt_q       <= RST_RELOAD;
            w5300_rst_q <= 1'b0;
            sl811_rst_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wr_rst && (bus.ports_wrdata[1:0] != 2'b00)) begin
                        state_q     <= ST_ASSERT;
                        cnt_q       <= RST_RELOAD;
                        w5300_rst_q <= ~bus.ports_wrdata[0];
                        sl811_rst_q <= ~bus.ports_wrdata[1];
                    end
                end
                ST_ASSERT: begin
                    if (cnt_q == 16'd0) begin
                        state_q     <= ST_RECOVER;
                        cnt_q       <= RCV_RELOAD;
                        w5300_rst_q <= 1'b1;
                        sl811_rst_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                ST_RECOVER: begin
                    if (cnt_q == 16'd0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= 16'd0;
                    w5300_rst_q <= 1'b1;
                    sl811_rst_q <= 1'b1;
                end
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);

    logic [7:0] int_rd;

`ifdef ZPORTS_INT_EN
    logic [1:0] wint_q;
    logic [1:0] sint_q;
    logic [1:0] pend_q;
    logic [1:0] pend_d;
    logic [1:0] mask_q;
    logic [1:0] mask_d;
    logic       int_req_q;
    logic       int_req_d;
    logic [1:0] set_v;
    logic [1:0] clr_v;
    logic       unused_wdata;

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            wint_q <= 2'b11;
            sint_q <= 2'b00;
        end else begin
            wint_q <= {wint_q[0], w5300_int_n};
            sint_q <= {sint_q[0], sl811_intrq};
        end
    end

    // A chip held in reset cannot raise a pending bit; a set beats a same-cycle W1C.
    assign set_v = {sint_q[1], ~wint_q[1]} & {sl811_rst_q, w5300_rst_q};
    assign clr_v = wr_int ? bus.ports_wrdata[1:0] : 2'b00;

    always_comb begin
        pend_d    = (pend_q & ~clr_v) | set_v;
        mask_d    = wr_int ? bus.ports_wrdata[5:4] : mask_q;
        int_req_d = |(pend_q & mask_q);
        if (soft_rst) begin
            pend_d    = 2'b00;
            mask_d    = 2'b00;
            int_req_d = 1'b0;
        end
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= 2'b00;
            mask_q    <= 2'b00;
            int_req_q <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            int_req_q <= int_req_d;
        end
    end

    assign int_rd       = {2'b00, mask_q, 2'b00, pend_q};
    assign int_req      = int_req_q;
    assign unused_wdata = ^bus.ports_wrdata[7:6];
`else
    logic unused_int;

    assign int_rd     = 8'h00;
    assign int_req    = 1'b0;
    assign unused_int = ^{bus.ports_wrdata[7:4], w5300_int_n, sl811_intrq, wr_int};
`endif

    always_comb begin
        bus.ports_rddata = 8'hFF;
        case (bus.ports_addr)
            2'b00:   bus.ports_rddata = 8'hFF;
            2'b01:   bus.ports_rddata = {4'h0, cfg_q};
            2'b10:   bus.ports_rddata = {busy, 5'b00000, sl811_rst_q, w5300_rst_q};
            2'b11:   bus.ports_rddata = int_rd;
            default: bus.ports_rddata = 8'hFF;
        endcase
    end

    assign rommap_ena  = cfg_q[0];
    assign rommap_win  = cfg_q[2:1];
    assign w5300_ports = cfg_q[3];
    assign w5300_rst_n = w5300_rst_q;
    assign sl811_rst_n = sl811_rst_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_zports.sv
// Self-checking bench for zports: power-on sequence, register writes (table + random model),
// reset pulses, interrupt latch (when ZPORTS_INT_EN is defined) and soft reset.
module tb_zports;

    localparam int RST_LEN = 4;
    localparam int RCV_LEN = 8;

    logic       fclk = 1'b0;
    logic       rst_n;
    logic       zrst_n;
    logic [1:0] rommap_win;
    logic       rommap_ena;
    logic       w5300_ports;
    logic       w5300_rst_n;
    logic       sl811_rst_n;
    logic       w5300_int_n;
    logic       sl811_intrq;
    logic       int_req;
    logic [1:0] dbg_state_o;

    zports_if bus ();

    zports #(.RST_LEN(RST_LEN), .RCV_LEN(RCV_LEN)) dut (
        .fclk        (fclk),
        .rst_n       (rst_n),
        .zrst_n      (zrst_n),
        .bus         (bus),
        .rommap_win  (rommap_win),
        .rommap_ena  (rommap_ena),
        .w5300_ports (w5300_ports),
        .w5300_rst_n (w5300_rst_n),
        .sl811_rst_n (sl811_rst_n),
        .w5300_int_n (w5300_int_n),
        .sl811_intrq (sl811_intrq),
        .int_req     (int_req),
        .dbg_state_o (dbg_state_o)
    );

    always #5 fclk = ~fclk;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];
    logic [3:0] m_cfg;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
        logic       en;
        logic [3:0] exp_cfg;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [7:0] exp);
        bus.ports_addr = a;
        #1;
        chk(name, {24'h0, bus.ports_rddata}, {24'h0, exp});
    endtask

    task automatic z_write(input logic [1:0] a, input logic [7:0] d, input logic en, input int low_cyc);
        @(posedge fclk);
        #1;
        bus.ports_addr    = a;
        bus.ports_wrdata  = d;
        bus.ports_wrena   = en;
        bus.ports_wrstb_n = 1'b0;
        repeat (low_cyc) @(posedge fclk);
        #1;
        bus.ports_wrstb_n = 1'b1;
        repeat (3) @(posedge fclk);
        #1;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge fclk);
            if (dbg_state_o == 2'd0) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: sequencer still busy after 200 cycles");
        end
    endtask

    task automatic mon(input int n, output int wl, output int sl, output int wf,
                       output int sf, output int bz);
        logic wp, sp;
        wl = 0; sl = 0; wf = 0; sf = 0; bz = 0;
        wp = 1'b1; sp = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge fclk);
            if (!w5300_rst_n) wl++;
            if (!sl811_rst_n) sl++;
            if (!w5300_rst_n && wp) wf++;
            if (!sl811_rst_n && sp) sf++;
            if (dbg_state_o != 2'd0) bz++;
            wp = w5300_rst_n;
            sp = sl811_rst_n;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int wl, sl, wf, sf, bz;
        logic [1:0] a;
        logic [7:0] d;
        logic en;
        logic [3:0] e;
        bit found;

        rst_n = 1'b0;
        zrst_n = 1'b1;
        w5300_int_n = 1'b1;
        sl811_intrq = 1'b0;
        bus.ports_wrena = 1'b0;
        bus.ports_wrstb_n = 1'b1;
        bus.ports_addr = 2'b00;
        bus.ports_wrdata = 8'h00;
        m_cfg = 4'h0;

        // Reset values
        repeat (3) @(posedge fclk);
        #1;
        chk("rst_rommap_ena", {31'h0, rommap_ena}, 32'h0);
        chk("rst_rommap_win", {30'h0, rommap_win}, 32'h0);
        chk("rst_w5300_ports", {31'h0, w5300_ports}, 32'h0);
        chk("rst_w5300_rst_n", {31'h0, w5300_rst_n}, 32'h0);
        chk("rst_sl811_rst_n", {31'h0, sl811_rst_n}, 32'h0);
        chk("rst_int_req", {31'h0, int_req}, 32'h0);
        rd_chk("rst_rd_cfg", 2'b01, 8'h00);
        rd_chk("rst_rd_int", 2'b11, 8'h00);
        rd_chk("rst_rd_rst", 2'b10, 8'h80);

        // Power-on sequence: ASSERT for RST_LEN, RECOVER for RCV_LEN, then idle
        @(posedge fclk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < RST_LEN + RCV_LEN + 4; i++) begin
            @(negedge fclk);
            if (i < RST_LEN) begin
                chk("por_rd", {24'h0, bus.ports_rddata}, 32'h80);
                chk("por_w5300_low", {31'h0, w5300_rst_n}, 32'h0);
            end else if (i < RST_LEN + RCV_LEN) begin
                chk("por_rd", {24'h0, bus.ports_rddata}, 32'h83);
                chk("por_sl811_high", {31'h0, sl811_rst_n}, 32'h1);
            end else begin
                chk("por_rd", {24'h0, bus.ports_rddata}, 32'h03);
            end
        end

        // CFG write latency: outputs change on the 3rd edge after the strobe falls
        @(posedge fclk);
        #1;
        bus.ports_addr = 2'b01;
        bus.ports_wrdata = 8'h0B;
        bus.ports_wrena = 1'b1;
        bus.ports_wrstb_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge fclk);
            chk("cfg_latency_ena", {31'h0, rommap_ena}, (k >= 3) ? 32'h1 : 32'h0);
        end
        repeat (3) @(posedge fclk);
        #1;
        bus.ports_wrstb_n = 1'b1;
        repeat (3) @(posedge fclk);
        #1;
        m_cfg = 4'hB;
        chk("cfg_win", {30'h0, rommap_win}, 32'h1);
        chk("cfg_w5300_ports", {31'h0, w5300_ports}, 32'h1);
        rd_chk("cfg_rd", 2'b01, 8'h0B);

        // Unqualified write and unstored address
        z_write(2'b01, 8'h00, 1'b0, 6);
        rd_chk("cfg_wrena0", 2'b01, 8'h0B);
        z_write(2'b00, 8'h00, 1'b1, 3);
        rd_chk("addr00_rd", 2'b00, 8'hFF);

        // Table-driven register writes
        vecs[0] = '{2'b01, 8'h05, 1'b1, 4'h5};
        vecs[1] = '{2'b01, 8'hF6, 1'b1, 4'h6};
        vecs[2] = '{2'b00, 8'h0F, 1'b1, 4'h6};
        vecs[3] = '{2'b01, 8'h09, 1'b0, 4'h6};
        vecs[4] = '{2'b10, 8'h00, 1'b1, 4'h6};
        vecs[5] = '{2'b01, 8'h08, 1'b1, 4'h8};
        vecs[6] = '{2'b01, 8'h00, 1'b1, 4'h0};
        for (int i = 0; i < 7; i++) begin
            z_write(vecs[i].addr, vecs[i].data, vecs[i].en, 3 + (i % 3));
            rd_chk("tbl_cfg_rd", 2'b01, {4'h0, vecs[i].exp_cfg});
            chk("tbl_ena", {31'h0, rommap_ena}, {31'h0, vecs[i].exp_cfg[0]});
            chk("tbl_win", {30'h0, rommap_win}, {30'h0, vecs[i].exp_cfg[2:1]});
            chk("tbl_ports", {31'h0, w5300_ports}, {31'h0, vecs[i].exp_cfg[3]});
            chk("tbl_no_reset", {30'h0, w5300_rst_n, sl811_rst_n}, 32'h3);
        end
        m_cfg = 4'h0;

        // Random writes against a register model
        for (int i = 0; i < 40; i++) begin
            a = 2'($urandom_range(2, 0));
            d = 8'($urandom_range(255, 0));
            en = 1'($urandom_range(1, 0));
            if (a == 2'b10) d = d & 8'hFC;
            if (en && a == 2'b01) m_cfg = d[3:0];
            exp_q.push_back(m_cfg);
            z_write(a, d, en, $urandom_range(8, 3));
            e = exp_q.pop_front();
            rd_chk("rnd_cfg_rd", 2'b01, {4'h0, e});
            chk("rnd_outputs", {28'h0, w5300_ports, rommap_win, rommap_ena}, {28'h0, e});
            rd_chk("rnd_rst_rd", 2'b10, 8'h03);
        end

        // SL811-only reset; a W5300 request while busy is ignored
        wait_idle();
        fork
            mon(40, wl, sl, wf, sf, bz);
            begin
                z_write(2'b10, 8'h02, 1'b1, 3);
                z_write(2'b10, 8'h01, 1'b1, 3);
            end
        join
        chk("sl_pulse_len", sl, RST_LEN);
        chk("sl_pulse_cnt", sf, 1);
        chk("sl_w5300_untouched", wl, 0);
        chk("sl_busy_len", bz, RST_LEN + RCV_LEN);

        // Long strobe produces a single commit
        wait_idle();
        fork
            mon(60, wl, sl, wf, sf, bz);
            z_write(2'b10, 8'h01, 1'b1, 30);
        join
        chk("long_w_len", wl, RST_LEN);
        chk("long_w_cnt", wf, 1);
        chk("long_sl_untouched", sl, 0);
        chk("long_busy_len", bz, RST_LEN + RCV_LEN);
        wait_idle();

`ifdef ZPORTS_INT_EN
        z_write(2'b11, 8'h10, 1'b1, 3);
        rd_chk("int_mask_rd", 2'b11, 8'h10);
        @(posedge fclk);
        #1;
        w5300_int_n = 1'b0;
        @(posedge fclk);
        #1;
        w5300_int_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge fclk);
            chk("int_latency", {31'h0, int_req}, (k == 3) ? 32'h1 : 32'h0);
        end
        rd_chk("int_pend_rd", 2'b11, 8'h11);

        w5300_int_n = 1'b0;
        repeat (3) @(posedge fclk);
        z_write(2'b11, 8'h01, 1'b1, 3);
        rd_chk("int_w1c_set_wins", 2'b11, 8'h11);
        chk("int_req_held", {31'h0, int_req}, 32'h1);
        w5300_int_n = 1'b1;
        repeat (4) @(posedge fclk);
        z_write(2'b11, 8'h11, 1'b1, 3);
        repeat (2) @(posedge fclk);
        #1;
        rd_chk("int_w1c_clear", 2'b11, 8'h10);
        chk("int_req_clear", {31'h0, int_req}, 32'h0);

        sl811_intrq = 1'b1;
        @(posedge fclk);
        #1;
        sl811_intrq = 1'b0;
        repeat (5) @(posedge fclk);
        #1;
        rd_chk("int_sl_masked_pend", 2'b11, 8'h12);
        chk("int_sl_masked_req", {31'h0, int_req}, 32'h0);
        z_write(2'b11, 8'h12, 1'b1, 3);
        rd_chk("int_sl_clear", 2'b11, 8'h10);

        // Source active only while its chip is held in reset must not latch
        @(posedge fclk);
        #1;
        bus.ports_addr = 2'b10;
        bus.ports_wrdata = 8'h01;
        bus.ports_wrena = 1'b1;
        bus.ports_wrstb_n = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge fclk);
            if (!w5300_rst_n) found = 1;
        end
        chk("int_blk_rst_seen", {31'h0, found}, 32'h1);
        w5300_int_n = 1'b0;
        @(negedge fclk);
        w5300_int_n = 1'b1;
        bus.ports_wrstb_n = 1'b1;
        wait_idle();
        repeat (4) @(posedge fclk);
        #1;
        rd_chk("int_blocked_in_reset", 2'b11, 8'h10);
        chk("int_blocked_req", {31'h0, int_req}, 32'h0);
`else
        rd_chk("noint_rd", 2'b11, 8'h00);
        z_write(2'b11, 8'h33, 1'b1, 3);
        rd_chk("noint_rd_after_wr", 2'b11, 8'h00);
        w5300_int_n = 1'b0;
        sl811_intrq = 1'b1;
        repeat (6) @(posedge fclk);
        #1;
        chk("noint_req", {31'h0, int_req}, 32'h0);
        w5300_int_n = 1'b1;
        sl811_intrq = 1'b0;
`endif

        // Soft reset in the middle of RECOVER
        wait_idle();
        z_write(2'b01, 8'h0B, 1'b1, 3);
        z_write(2'b10, 8'h03, 1'b1, 3);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge fclk);
            if (dbg_state_o == 2'd2) found = 1;
        end
        chk("soft_reached_recover", {31'h0, found}, 32'h1);
        repeat (2) @(posedge fclk);
        #1;
        zrst_n = 1'b0;
        repeat (5) @(posedge fclk);
        @(negedge fclk);
        chk("soft_rst_both_low", {30'h0, w5300_rst_n, sl811_rst_n}, 32'h0);
        chk("soft_cfg_outputs", {28'h0, w5300_ports, rommap_win, rommap_ena}, 32'h0);
        rd_chk("soft_cfg_rd", 2'b01, 8'h00);
        rd_chk("soft_int_rd", 2'b11, 8'h00);
        @(posedge fclk);
        #1;
        zrst_n = 1'b1;
        // Two extra cycles of hold while the release crosses the synchronizer
        mon(40, wl, sl, wf, sf, bz);
        chk("soft_w_len", wl, RST_LEN + 2);
        chk("soft_sl_len", sl, RST_LEN + 2);
        chk("soft_w_cnt", wf, 1);
        chk("soft_busy_len", bz, RST_LEN + 2 + RCV_LEN);
        rd_chk("soft_cfg_after", 2'b01, 8'h00);
        rd_chk("soft_rst_after", 2'b10, 8'h03);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
